// File: rtl/mem_arbiter.sv
// Block-transfer arbiter sharing one main-memory port between the I-cache and D-cache controllers.
// Round-robin between sides; a D write-back stays atomic with the refill read that follows it.
module mem_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int BLOCK_W = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               icRen,
  input  logic [ADDR_W-1:0]  icBlockAddr,
  output logic               icReadReady,
  output logic [BLOCK_W-1:0] icDout,
  input  logic               dcRen,
  input  logic               dcWen,
  input  logic [ADDR_W-1:0]  dcBlockAddr,
  input  logic [BLOCK_W-1:0] dcDin,
  output logic               dcReadReady,
  output logic               dcWriteDone,
  output logic [BLOCK_W-1:0] dcDout,
  output logic               memRen,
  output logic               memWen,
  output logic [ADDR_W-1:0]  memBlockAddr,
  output logic [BLOCK_W-1:0] memDin,
  input  logic               memReadReady,
  input  logic               memWriteDone,
  input  logic [BLOCK_W-1:0] memDout
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] IC_READ  = 3'd1;
  localparam logic [2:0] DC_READ  = 3'd2;
  localparam logic [2:0] DC_WRITE = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [2:0] state;
  logic       last_grant;
  logic       lock_d;
  logic       d_req;
  logic       locked_read;
  logic       tie;
  logic       grant_d;
  logic       grant_i;
  logic       d_write;
  logic       xfer_done;

  // A pending write-back lock overrides round-robin and the write-over-read preference.
  assign d_req       = dcWen | dcRen;
  assign locked_read = lock_d & dcRen;
  assign tie         = d_req & icRen;
  assign grant_d     = locked_read | (tie ? (last_grant == GRANT_I) : d_req);
  assign grant_i     = ~grant_d & icRen;
  assign d_write     = dcWen & ~locked_read;

  assign icReadReady = (state == IC_READ)  & memReadReady;
  assign dcReadReady = (state == DC_READ)  & memReadReady;
  assign dcWriteDone = (state == DC_WRITE) & memWriteDone;
  assign xfer_done   = icReadReady | dcReadReady | dcWriteDone;

  assign icDout = icReadReady ? memDout : '0;
  assign dcDout = dcReadReady ? memDout : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= GRANT_D;
      lock_d       <= 1'b0;
      memRen       <= 1'b0;
      memWen       <= 1'b0;
      memBlockAddr <= '0;
      memDin       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The lock lives for exactly one arbitration: used by the refill read or dropped.
          lock_d <= 1'b0;
          if (grant_d) begin
            last_grant   <= GRANT_D;
            memBlockAddr <= dcBlockAddr;
            if (d_write) begin
              state  <= DC_WRITE;
              memWen <= 1'b1;
              memDin <= dcDin;
            end else begin
              state  <= DC_READ;
              memRen <= 1'b1;
            end
          end else if (grant_i) begin
            last_grant   <= GRANT_I;
            state        <= IC_READ;
            memRen       <= 1'b1;
            memBlockAddr <= icBlockAddr;
          end
        end
        IC_READ, DC_READ, DC_WRITE: begin
          if (xfer_done) begin
            state        <= GAP;
            memRen       <= 1'b0;
            memWen       <= 1'b0;
            memBlockAddr <= '0;
            memDin       <= '0;
            if (dcWriteDone) lock_d <= 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory block port between the instruction-cache controller (read-only) and the data-cache controller (read and write-back).
- Sits between both cache controllers and the memory model, and sequences one block transfer at a time.
- Round-robin fairness between the I and D sides.
- A D-side write-back is kept atomic with its following refill read, so the I side cannot slip in between them.

Parameters:
- ADDR_W, 30, block address width in bits.
- BLOCK_W, 256, cache block data width in bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- icRen  in  1  I-side block read request; held until icReadReady.
- icBlockAddr  in  ADDR_W  I-side block address.
- icReadReady  out  1  one-cycle pulse: icDout is valid.
- icDout  out  BLOCK_W  I-side read data.
- dcRen  in  1  D-side block read request; held until dcReadReady.
- dcWen  in  1  D-side block write request; held until dcWriteDone.
- dcBlockAddr  in  ADDR_W  D-side block address.
- dcDin  in  BLOCK_W  D-side write data.
- dcReadReady  out  1  one-cycle pulse: dcDout is valid.
- dcWriteDone  out  1  one-cycle pulse: write accepted by memory.
- dcDout  out  BLOCK_W  D-side read data.
- memRen  out  1  memory read enable.
- memWen  out  1  memory write enable.
- memBlockAddr  out  ADDR_W  memory block address.
- memDin  out  BLOCK_W  memory write data.
- memReadReady  in  1  memory read data valid (one-cycle pulse).
- memWriteDone  in  1  memory write complete (one-cycle pulse).
- memDout  in  BLOCK_W  memory read data.

Behaviour:
- States: IDLE, IC_READ, DC_READ, DC_WRITE, GAP.
- Reset (asynchronous, while reset=0):
  - state=IDLE, lastGrant=D, lockD=0.
  - memRen, memWen, memBlockAddr, memDin all 0.
  - All ready/done pulses 0; icDout and dcDout 0.
  - A reset mid-transfer abandons the transfer with no completion pulse. Memory is expected to be reset alongside.
- IDLE arbitration, evaluated at each clock edge:
  - lockD=1 and dcRen=1: go to DC_READ; clear lockD.
  - Otherwise dcWen has priority over dcRen within the D side.
  - If only one side requests, that side is granted.
  - If both sides request, the side not equal to lastGrant wins. After reset the I side wins the first tie.
  - Grant updates lastGrant. Entry states: DC_WRITE for dcWen, DC_READ for dcRen, IC_READ for icRen.
  - No request: stay in IDLE with all memory outputs 0.
- Memory outputs are registered and loaded on entry to a transfer state:
  - memBlockAddr from the granted requester.
  - memDin from dcDin (DC_WRITE only).
  - memRen=1 in IC_READ and DC_READ; memWen=1 in DC_WRITE.
  - All held stable until completion.
  - Latency: request seen at edge t gives memory enable high in cycle t+1.
- Completion:
  - IC_READ + memReadReady: icReadReady=1 combinationally in that cycle, icDout=memDout.
  - DC_READ + memReadReady: dcReadReady=1, dcDout=memDout.
  - DC_WRITE + memWriteDone: dcWriteDone=1 and lockD is set.
  - Next edge goes to GAP; memRen and memWen drop to 0.
- icDout/dcDout pass memDout through only while the corresponding ready is high; otherwise 0.
- GAP: one cycle with requests ignored, so requesters can deassert. Then IDLE.
- Ignored events:
  - memReadReady in IDLE, GAP or DC_WRITE.
  - memWriteDone in any state except DC_WRITE.
- Requester-side invariants:
  - Requests and addresses are assumed stable while pending. The arbiter never re-samples them after grant.
  - Dropping a request before completion is illegal. The transfer still completes and the pulse is still issued.
- lockD is cleared if dcRen=0 when the arbiter reaches IDLE from the write-back GAP, so a lone write does not starve the I side.
- No per-requester timeout; memory must eventually respond.

Test Plan:
- Single I read:
  - Stimulus: icRen=1, icBlockAddr=0x100; memory returns memDout=0xA5.. after 3 cycles.
  - Response: memRen high from cycle 1 with memBlockAddr=0x100; icReadReady pulses once with icDout=0xA5..; then GAP; then IDLE with memRen=0.
- Tie after reset:
  - Stimulus: icRen=1 and dcRen=1 asserted together.
  - Response: I side granted first; the D read is granted immediately after the I GAP; dcReadReady follows.
- Write-back lock:
  - Stimulus: dcWen=1, dcBlockAddr=0x20, dcDin=0x11..; then dcRen=1, dcBlockAddr=0x40, with icRen=1 pending throughout.
  - Response: sequence is DC_WRITE (memWen, addr 0x20), then DC_READ (addr 0x40), then IC_READ. The I side is not granted in between.
- Spurious handshakes:
  - Stimulus: memReadReady pulsed in IDLE, and memWriteDone pulsed during IC_READ.
  - Response: no ready or done outputs; state unchanged.
- Reset mid-transfer:
  - Stimulus: reset driven low during DC_READ, between clock edges.
  - Response: memRen=0 immediately (asynchronous); no dcReadReady; state=IDLE after release.
- Alternation under continuous load:
  - Stimulus: icRen and dcRen both held high for 4 transfers.
  - Response: grants alternate I, D, I, D.
